// File: rtl/tlu_emulator.sv
// Transmitter end of the EUDET TLU trigger handshake: issues periodic triggers
// and shifts the trigger number out LSB-first on the DUT's TLU_CLOCK edges.
module tlu_emulator #(
  parameter int TRIGGER_BITS = 16,
  parameter int TIMEOUT      = 65535
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_B,
  input  logic                    START,
  input  logic                    STOP,
  input  logic [31:0]             TRIGGER_PERIOD,
  input  logic [31:0]             TRIGGER_COUNT,
  output logic                    TLU_TRIGGER,
  input  logic                    TLU_BUSY,
  input  logic                    TLU_CLOCK,
  output logic [TRIGGER_BITS-1:0] TRIGGER_NUMBER,
  output logic                    RUNNING,
  output logic                    TIMEOUT_ERR,
  output logic [15:0]             LATE_CNT
);

  localparam int IDX_W = (TRIGGER_BITS > 1) ? $clog2(TRIGGER_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(TRIGGER_BITS - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    TRIG,
    SHIFT,
    RELEASE
  } state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              busy_sync_reg;
  logic [2:0]              clk_sync_reg;
  logic [31:0]             period_cnt_reg, period_cnt_next;
  logic [31:0]             to_cnt_reg, to_cnt_next;
  logic [31:0]             sent_reg, sent_next;
  logic [TRIGGER_BITS-1:0] num_reg, num_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [15:0]             late_reg, late_next;
  logic                    trig_reg, trig_next;
  logic                    running_reg, running_next;
  logic                    terr_reg, terr_next;
  logic                    stop_pend_reg, stop_pend_next;
  logic                    first_reg, first_next;

  logic        busy_s;
  logic        clk_s;
  logic        clk_rise;
  logic [31:0] period_last;
  logic        expired;
  logic        handshake;
  logic        timed_out;
  logic        finish;
  logic        abort;

  assign busy_s   = busy_sync_reg[1];
  assign clk_s    = clk_sync_reg[1];
  assign clk_rise = clk_sync_reg[1] & ~clk_sync_reg[2];

  // A period of 0 behaves like 1: the counter is always expired.
  assign period_last = (TRIGGER_PERIOD == 32'd0) ? 32'd0 : TRIGGER_PERIOD - 32'd1;
  assign expired     = (period_cnt_reg >= period_last);

  assign handshake = (state_reg == TRIG) || (state_reg == SHIFT) || (state_reg == RELEASE);
  assign timed_out = handshake && (to_cnt_reg >= TIMEOUT_LAST);

  always_comb begin
    state_next     = state_reg;
    sent_next      = sent_reg;
    num_next       = num_reg;
    idx_next       = idx_reg;
    late_next      = late_reg;
    trig_next      = trig_reg;
    running_next   = running_reg;
    terr_next      = terr_reg;
    stop_pend_next = stop_pend_reg;
    first_next     = first_reg;
    finish         = 1'b0;
    abort          = 1'b0;

    if (!running_reg)
      period_cnt_next = 32'd0;
    else if (period_cnt_reg == 32'hFFFF_FFFF)
      period_cnt_next = period_cnt_reg;
    else
      period_cnt_next = period_cnt_reg + 32'd1;

    to_cnt_next = handshake ? to_cnt_reg + 32'd1 : 32'd0;

    case (state_reg)
      IDLE: begin
        if (START) begin
          state_next     = WAIT_PERIOD;
          running_next   = 1'b1;
          terr_next      = 1'b0;
          late_next      = 16'd0;
          sent_next      = 32'd0;
          stop_pend_next = 1'b0;
          first_next     = 1'b1;
        end
      end

      WAIT_PERIOD: begin
        if (STOP) begin
          state_next   = IDLE;
          running_next = 1'b0;
        end else if (expired || first_reg) begin
          state_next      = TRIG;
          trig_next       = 1'b1;
          to_cnt_next     = 32'd0;
          period_cnt_next = 32'd0;
          first_next      = 1'b0;
        end
      end

      TRIG: begin
        stop_pend_next = stop_pend_reg | STOP;
        if (busy_s) begin
          state_next  = SHIFT;
          trig_next   = 1'b0;
          idx_next    = '0;
          to_cnt_next = 32'd0;
        end else if (timed_out) begin
          finish = 1'b1;
          abort  = 1'b1;
        end
      end

      SHIFT: begin
        stop_pend_next = stop_pend_reg | STOP;
        if (clk_rise) begin
          trig_next   = num_reg[idx_reg];
          idx_next    = idx_reg + IDX_W'(1);
          to_cnt_next = 32'd0;
          if (idx_reg == LAST_IDX)
            state_next = RELEASE;
        end else if (timed_out) begin
          finish = 1'b1;
          abort  = 1'b1;
        end
      end

      RELEASE: begin
        stop_pend_next = stop_pend_reg | STOP;
        // Keep the last bit up until the DUT drops its clock, so it can sample it.
        if (!clk_s)
          trig_next = 1'b0;
        if (!busy_s) begin
          finish = 1'b1;
        end else if (timed_out) begin
          finish = 1'b1;
          abort  = 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        running_next = 1'b0;
        trig_next    = 1'b0;
      end
    endcase

    // A completed or aborted handshake both consume a trigger number.
    if (finish) begin
      trig_next   = 1'b0;
      to_cnt_next = 32'd0;
      num_next    = num_reg + TRIGGER_BITS'(1);
      sent_next   = sent_reg + 32'd1;
      if (abort)
        terr_next = 1'b1;
      if (((TRIGGER_COUNT != 32'd0) && (sent_next == TRIGGER_COUNT)) || stop_pend_next) begin
        state_next     = IDLE;
        running_next   = 1'b0;
        stop_pend_next = 1'b0;
      end else begin
        state_next = WAIT_PERIOD;
        if (expired && (late_reg != 16'hFFFF))
          late_next = late_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      state_reg      <= IDLE;
      busy_sync_reg  <= 2'b00;
      clk_sync_reg   <= 3'b000;
      period_cnt_reg <= 32'd0;
      to_cnt_reg     <= 32'd0;
      sent_reg       <= 32'd0;
      num_reg        <= '0;
      idx_reg        <= '0;
      late_reg       <= 16'd0;
      trig_reg       <= 1'b0;
      running_reg    <= 1'b0;
      terr_reg       <= 1'b0;
      stop_pend_reg  <= 1'b0;
      first_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      busy_sync_reg  <= {busy_sync_reg[0], TLU_BUSY};
      clk_sync_reg   <= {clk_sync_reg[1:0], TLU_CLOCK};
      period_cnt_reg <= period_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      sent_reg       <= sent_next;
      num_reg        <= num_next;
      idx_reg        <= idx_next;
      late_reg       <= late_next;
      trig_reg       <= trig_next;
      running_reg    <= running_next;
      terr_reg       <= terr_next;
      stop_pend_reg  <= stop_pend_next;
      first_reg      <= first_next;
    end
  end

  assign TLU_TRIGGER    = trig_reg;
  assign TRIGGER_NUMBER = num_reg;
  assign RUNNING        = running_reg;
  assign TIMEOUT_ERR    = terr_reg;
  assign LATE_CNT       = late_reg;

endmodule

// File: tb/tb_tlu_emulator.sv
// Bench for tlu_emulator: a DUT-side responder answers triggers and a scoreboard
// compares each shifted trigger number and its timing with queued expectations.
module tb_tlu_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst_n;
  logic        start_a, stop_a, start_b, stop_b;
  logic [31:0] period_a, count_a, period_b, count_b;
  logic        busy, tclk;
  logic        trig_a, trig_b, run_a, run_b, terr_a, terr_b;
  logic [15:0] num_a, late_a, late_b;
  logic [3:0]  num_b;

  // Main instance: 16-bit numbers, long timeout.
  tlu_emulator #(.TRIGGER_BITS(16), .TIMEOUT(400)) u_dut (
    .BUS_CLK(clk), .BUS_RST_B(rst_n), .START(start_a), .STOP(stop_a),
    .TRIGGER_PERIOD(period_a), .TRIGGER_COUNT(count_a), .TLU_TRIGGER(trig_a),
    .TLU_BUSY(busy), .TLU_CLOCK(tclk), .TRIGGER_NUMBER(num_a), .RUNNING(run_a),
    .TIMEOUT_ERR(terr_a), .LATE_CNT(late_a)
  );

  // Small instance: 4-bit numbers and a 50-cycle timeout for timeout/wrap cases.
  tlu_emulator #(.TRIGGER_BITS(4), .TIMEOUT(50)) u_dut_b (
    .BUS_CLK(clk), .BUS_RST_B(rst_n), .START(start_b), .STOP(stop_b),
    .TRIGGER_PERIOD(period_b), .TRIGGER_COUNT(count_b), .TLU_TRIGGER(trig_b),
    .TLU_BUSY(busy), .TLU_CLOCK(tclk), .TRIGGER_NUMBER(num_b), .RUNNING(run_b),
    .TIMEOUT_ERR(terr_b), .LATE_CNT(late_b)
  );

  logic        sel = 1'b0;
  logic        mon_trig, mon_terr;
  logic [15:0] mon_num;
  assign mon_trig = sel ? trig_b : trig_a;
  assign mon_terr = sel ? terr_b : terr_a;
  assign mon_num  = sel ? {12'd0, num_b} : num_a;

  // mode: 0 respond, 1 mute (never BUSY), 2 abort after nbits clocks
  // gap_mode: 0 none, 1 start-to-start == val, 2 BUSY release to start <= val, 3 START to start == 2
  typedef struct {
    int num;
    int mode;
    int nbits;
    int busy_len;
    int gap_mode;
    int gap_val;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   start_cyc = 0;
  int   bits_sent = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_le(string name, longint act, longint lim);
    checks++;
    if (act > lim || act < 0) begin
      failures++;
      $display("FAIL %s actual=%0d expected<=%0d (cycle %0d)", name, act, lim, cyc);
    end
  endfunction

  function automatic void push(int num, int mode, int nbits, int busy_len, int gm, int gv);
    rec_t r;
    r.num = num; r.mode = mode; r.nbits = nbits;
    r.busy_len = busy_len; r.gap_mode = gm; r.gap_val = gv;
    exp_q.push_back(r);
  endfunction

  // Responder + monitor: plays the DUT side and scores every trigger seen.
  initial begin : monitor
    logic        prev;
    int          rise, hi, brise, start_prev, rel_prev;
    rec_t        r;
    logic [15:0] got;
    prev = 1'b0; start_prev = 0; rel_prev = 0;
    busy = 1'b0; tclk = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_trig && !prev) begin
        rise = cyc;
        bits_sent = 0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_trigger actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          r = exp_q.pop_front();
          case (r.gap_mode)
            1: chk("start_gap", rise - start_prev, r.gap_val);
            2: chk_le("release_gap", rise - rel_prev, r.gap_val);
            3: chk("first_latency", rise - start_cyc, 2);
            default: ;
          endcase
          start_prev = rise;
          if (r.mode == 1) begin
            hi = 0;
            while (mon_trig && hi < 200) begin hi++; @(negedge clk); end
            chk("timeout_len", hi, 50);
            chk("timeout_err", mon_terr, 1);
            chk("num_after_timeout", mon_num, (r.num + 1) % 16);
          end else begin
            repeat (5) @(negedge clk);
            busy = 1'b1; brise = cyc;
            repeat (4) @(negedge clk);
            got = 16'd0;
            for (int b = 0; b < r.nbits; b++) begin
              tclk = 1'b1;
              repeat (4) @(negedge clk);
              got[b] = mon_trig;
              tclk = 1'b0;
              repeat (4) @(negedge clk);
              bits_sent = b + 1;
            end
            if (r.mode == 0) begin
              while (cyc - brise < r.busy_len) @(negedge clk);
              busy = 1'b0; rel_prev = cyc;
              chk("shifted_number", got, r.num);
              bits_sent = 0;
            end else begin
              busy = 1'b0;
            end
          end
        end
      end
      prev = mon_trig;
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start(input bit which);
    start_cyc = cyc;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk("running_after_start", which ? run_b : run_a, 1);
  endtask

  task automatic wait_idle(input bit which, input int limit);
    int n = 0;
    while ((which ? run_b : run_a) && n < limit) begin @(negedge clk); n++; end
    chk("run_done", which ? run_b : run_a, 0);
  endtask

  initial begin : stimulus
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    period_a = 32'd0; count_a = 32'd0; period_b = 32'd0; count_b = 32'd0;
    #1;
    chk("rst_trigger", trig_a, 0);
    chk("rst_running", run_a, 0);
    chk("rst_number", num_a, 0);
    chk("rst_timeout_err", terr_a, 0);
    chk("rst_late", late_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal run: three triggers, 200 cycles apart.
    period_a = 32'd200; count_a = 32'd3;
    push(0, 0, 16, 0, 3, 0);
    push(1, 0, 16, 0, 1, 200);
    push(2, 0, 16, 0, 1, 200);
    pulse_start(1'b0);
    wait_idle(1'b0, 2000);
    chk("t1_number", num_a, 3);
    chk("t1_late", late_a, 0);
    chk("t1_timeout_err", terr_a, 0);
    repeat (20) @(negedge clk);

    // Long BUSY: every release arrives after the period expired.
    period_a = 32'd100; count_a = 32'd4;
    push(3, 0, 16, 300, 3, 0);
    push(4, 0, 16, 300, 2, 5);
    push(5, 0, 16, 300, 2, 5);
    push(6, 0, 16, 300, 2, 5);
    pulse_start(1'b0);
    wait_idle(1'b0, 3000);
    chk("t2_number", num_a, 7);
    chk("t2_late", late_a, 3);
    repeat (20) @(negedge clk);

    // Small instance: 15 lost triggers, then all-ones shifted and wrap to 0.
    sel = 1'b1;
    period_b = 32'd1; count_b = 32'd16;
    push(0, 1, 0, 0, 3, 0);
    for (int i = 1; i < 15; i++) push(i, 1, 0, 0, 0, 0);
    push(15, 0, 4, 0, 0, 0);
    pulse_start(1'b1);
    wait_idle(1'b1, 5000);
    chk("b_number_wrap", num_b, 0);
    chk("b_late", late_b, 15);
    chk("b_timeout_err", terr_b, 1);
    repeat (20) @(negedge clk);
    sel = 1'b0;

    // Unlimited run stopped mid-shift: the handshake completes, nothing follows.
    period_a = 32'd200; count_a = 32'd0;
    push(7, 0, 16, 0, 3, 0);
    pulse_start(1'b0);
    n = 0;
    while (bits_sent < 4 && n < 2000) begin @(negedge clk); n++; end
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    wait_idle(1'b0, 2000);
    repeat (400) @(negedge clk);
    chk("t5_number", num_a, 8);
    chk("t5_running", run_a, 0);

    // Asynchronous reset in the middle of a shift.
    count_a = 32'd1;
    push(8, 2, 8, 0, 3, 0);
    pulse_start(1'b0);
    n = 0;
    while (bits_sent < 8 && n < 2000) begin @(negedge clk); n++; end
    chk("t6_reached_shift", (bits_sent >= 8) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_trigger", trig_a, 0);
    chk("t6_rst_running", run_a, 0);
    chk("t6_rst_number", num_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(0, 0, 16, 0, 3, 0);
    pulse_start(1'b0);
    wait_idle(1'b0, 2000);
    chk("t6_restart_number", num_a, 1);
    repeat (20) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
